// File: rtl/ap_cam_ctrl_if.sv
// Host-side command/response bundle for the CAM sequencer.
// The host drives through the master modport and the sequencer through slave.
interface ap_cam_ctrl_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int DATA_DEPTH     = 16,
  parameter int ADDR_WIDTH_CAM = 8
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [2:0]                cmd_op;
  logic [ADDR_WIDTH_CAM-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0]     cmd_row_data;
  logic [DATA_DEPTH-1:0]     cmd_col_data;
  logic [DATA_WIDTH-1:0]     cmd_cmp_mask;
  logic [DATA_WIDTH-1:0]     cmd_wr_mask;
  logic                      cmd_key;
  logic                      rsp_valid;
  logic                      rsp_err;
  logic [DATA_WIDTH-1:0]     rsp_data_row;
  logic [DATA_DEPTH-1:0]     rsp_data_col;
  logic [DATA_DEPTH-1:0]     rsp_tag;
  logic                      rsp_hit;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_row_data, cmd_col_data,
           cmd_cmp_mask, cmd_wr_mask, cmd_key,
    input  cmd_ready, rsp_valid, rsp_err, rsp_data_row, rsp_data_col,
           rsp_tag, rsp_hit
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_row_data, cmd_col_data,
           cmd_cmp_mask, cmd_wr_mask, cmd_key,
    output cmd_ready, rsp_valid, rsp_err, rsp_data_row, rsp_data_col,
           rsp_tag, rsp_hit
  );
endinterface

// File: rtl/ap_cam_ctrl.sv
// Command sequencer for the associative-processor CAM array: turns one host
// command at a time into cycle-exact array control and returns one response.
module ap_cam_ctrl #(
  parameter int         DATA_WIDTH     = 8,
  parameter int         DATA_DEPTH     = 16,
  parameter int         ADDR_WIDTH_CAM = 8,
  parameter logic [2:0] MODE_IDLE      = 3'd0,
  parameter logic [2:0] MODE_ROWXROW   = 3'd1,
  parameter logic [2:0] MODE_COLXCOL   = 3'd2,
  parameter logic [2:0] MODE_COPY_R    = 3'd4,
  parameter logic [2:0] MODE_COPY_A    = 3'd5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  ap_cam_ctrl_if.slave              host,
  output logic [2:0]                ap_input_mode,
  output logic                      ap_rst_In,
  output logic [ADDR_WIDTH_CAM-1:0] ap_addr_input_rbr,
  output logic [ADDR_WIDTH_CAM-1:0] ap_addr_input_cbc,
  output logic [ADDR_WIDTH_CAM-1:0] ap_addr_output_rbr,
  output logic [ADDR_WIDTH_CAM-1:0] ap_addr_output_cbc,
  output logic [DATA_WIDTH-1:0]     ap_input_row,
  output logic [DATA_DEPTH-1:0]     ap_input_col,
  output logic [DATA_WIDTH-1:0]     ap_mask,
  output logic                      ap_key,
  output logic [DATA_DEPTH-1:0]     ap_tag,
  input  logic [DATA_WIDTH-1:0]     ap_Q_out_row,
  input  logic [DATA_DEPTH-1:0]     ap_Q_out_col,
  input  logic [DATA_DEPTH-1:0]     ap_tag_row
);
  typedef enum logic [2:0] {
    OP_NOP, OP_WR_ROW, OP_WR_COL, OP_RD_ROW, OP_RD_COL, OP_SEARCH, OP_SEARCH_TOGGLE, OP_COPY
  } op_t;
  typedef enum logic [2:0] {IDLE, EXEC, TOGGLE, RD1, RD2, RESP} state_t;

  localparam logic [ADDR_WIDTH_CAM-1:0] DEPTH_ADDR    = ADDR_WIDTH_CAM'(DATA_DEPTH);
  localparam logic [ADDR_WIDTH_CAM-1:0] WIDTH_ADDR    = ADDR_WIDTH_CAM'(DATA_WIDTH);
  localparam logic [ADDR_WIDTH_CAM-1:0] IDLE_ROW_ADDR = ADDR_WIDTH_CAM'(DATA_DEPTH + 3);
  localparam logic [ADDR_WIDTH_CAM-1:0] IDLE_COL_ADDR = ADDR_WIDTH_CAM'(DATA_WIDTH + 3);

  state_t                    state_reg, state_next;
  op_t                       op_reg;
  logic [ADDR_WIDTH_CAM-1:0] addr_reg;
  logic [DATA_WIDTH-1:0]     row_data_reg, cmp_mask_reg, wr_mask_reg;
  logic [DATA_DEPTH-1:0]     col_data_reg, tag_reg;
  logic                      key_reg;
  logic                      rsp_err_reg;
  logic [DATA_WIDTH-1:0]     rsp_row_reg;
  logic [DATA_DEPTH-1:0]     rsp_col_reg, rsp_tag_reg;
  logic                      addr_err, cmd_ready, rsp_valid;
  op_t                       cmd_op;

  assign cmd_op = op_t'(host.cmd_op);

  always_comb begin
    addr_err = 1'b0;
    case (cmd_op)
      OP_WR_ROW, OP_RD_ROW: addr_err = (host.cmd_addr >= DEPTH_ADDR);
      OP_WR_COL, OP_RD_COL: addr_err = (host.cmd_addr >= WIDTH_ADDR);
      default:              addr_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (host.cmd_valid)
                 state_next = (cmd_op == OP_NOP || addr_err) ? RESP : EXEC;
      EXEC:    if (op_reg == OP_RD_ROW || op_reg == OP_RD_COL) state_next = RD1;
               else if (op_reg == OP_SEARCH_TOGGLE)             state_next = TOGGLE;
               else                                             state_next = RESP;
      TOGGLE:  state_next = RESP;
      RD1:     state_next = RD2;
      RD2:     state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Idle drive is the default; only EXEC/TOGGLE/RD* override it.
  always_comb begin
    ap_input_mode      = MODE_IDLE;
    ap_rst_In          = 1'b1;
    ap_addr_input_rbr  = '0;
    ap_addr_input_cbc  = '0;
    ap_addr_output_rbr = IDLE_ROW_ADDR;
    ap_addr_output_cbc = IDLE_COL_ADDR;
    ap_input_row       = '0;
    ap_input_col       = '0;
    ap_mask            = '0;
    ap_key             = 1'b0;
    ap_tag             = '0;
    rsp_valid          = (state_reg == RESP);
    cmd_ready          = rst_n && (state_reg == IDLE);
    case (state_reg)
      EXEC: begin
        case (op_reg)
          OP_WR_ROW: begin
            ap_input_mode     = MODE_ROWXROW;
            ap_rst_In         = 1'b0;
            ap_addr_input_rbr = addr_reg;
            ap_input_row      = row_data_reg;
          end
          OP_WR_COL: begin
            ap_input_mode     = MODE_COLXCOL;
            ap_rst_In         = 1'b0;
            ap_addr_input_cbc = addr_reg;
            ap_input_col      = col_data_reg;
          end
          OP_SEARCH, OP_SEARCH_TOGGLE: begin
            ap_mask = cmp_mask_reg;
            ap_key  = key_reg;
          end
          OP_COPY: begin
            ap_input_mode = key_reg ? MODE_COPY_A : MODE_COPY_R;
            ap_rst_In     = 1'b0;
          end
          default: ;
        endcase
      end
      TOGGLE: begin
        ap_mask = wr_mask_reg;
        ap_tag  = tag_reg;
      end
      default: ;
    endcase
    // Read address and mode stay put until the registered array output is captured.
    if (state_reg == EXEC || state_reg == RD1 || state_reg == RD2) begin
      if (op_reg == OP_RD_ROW) begin
        ap_input_mode      = MODE_ROWXROW;
        ap_addr_output_rbr = addr_reg;
      end else if (op_reg == OP_RD_COL) begin
        ap_input_mode      = MODE_COLXCOL;
        ap_addr_output_cbc = addr_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg       <= OP_NOP;
      addr_reg     <= '0;
      row_data_reg <= '0;
      col_data_reg <= '0;
      cmp_mask_reg <= '0;
      wr_mask_reg  <= '0;
      key_reg      <= 1'b0;
      tag_reg      <= '0;
      rsp_err_reg  <= 1'b0;
      rsp_row_reg  <= '0;
      rsp_col_reg  <= '0;
      rsp_tag_reg  <= '0;
    end else begin
      if (state_reg == IDLE && host.cmd_valid) begin
        op_reg       <= cmd_op;
        addr_reg     <= host.cmd_addr;
        row_data_reg <= host.cmd_row_data;
        col_data_reg <= host.cmd_col_data;
        cmp_mask_reg <= host.cmd_cmp_mask;
        wr_mask_reg  <= host.cmd_wr_mask;
        key_reg      <= host.cmd_key;
        if (addr_err) begin
          rsp_row_reg <= '0;
          rsp_col_reg <= '0;
        end
      end
      // rsp_err changes only on the edge that enters RESP, so it holds between responses.
      if (state_next == RESP && state_reg != RESP)
        rsp_err_reg <= (state_reg == IDLE) && addr_err;
      if (state_reg == EXEC && (op_reg == OP_SEARCH || op_reg == OP_SEARCH_TOGGLE)) begin
        tag_reg <= ap_tag_row;
        if (op_reg == OP_SEARCH) rsp_tag_reg <= ap_tag_row;
      end
      if (state_reg == TOGGLE) rsp_tag_reg <= tag_reg;
      if (state_reg == RD2) begin
        if (op_reg == OP_RD_ROW) rsp_row_reg <= ap_Q_out_row;
        else                     rsp_col_reg <= ap_Q_out_col;
      end
    end
  end

  assign host.cmd_ready    = cmd_ready;
  assign host.rsp_valid    = rsp_valid;
  assign host.rsp_err      = rsp_err_reg;
  assign host.rsp_data_row = rsp_row_reg;
  assign host.rsp_data_col = rsp_col_reg;
  assign host.rsp_tag      = rsp_tag_reg;
  assign host.rsp_hit      = |rsp_tag_reg;
endmodule

// File: tb/tb_ap_cam_ctrl.sv
// Bench for ap_cam_ctrl: behavioural CAM array model, directed commands with
// hand-computed responses pushed to a scoreboard, and a decoupled monitor.
module tb_ap_cam_ctrl;
  localparam int W = 8;
  localparam int D = 16;
  localparam int A = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ap_cam_ctrl_if #(.DATA_WIDTH(W), .DATA_DEPTH(D), .ADDR_WIDTH_CAM(A)) bus ();

  logic [2:0]   ap_input_mode;
  logic         ap_rst_In;
  logic [A-1:0] ap_addr_input_rbr, ap_addr_input_cbc, ap_addr_output_rbr, ap_addr_output_cbc;
  logic [W-1:0] ap_input_row, ap_mask;
  logic [D-1:0] ap_input_col, ap_tag;
  logic         ap_key;
  logic [W-1:0] ap_Q_out_row = '0;
  logic [D-1:0] ap_Q_out_col = '0;
  logic [D-1:0] ap_tag_row;

  ap_cam_ctrl #(.DATA_WIDTH(W), .DATA_DEPTH(D), .ADDR_WIDTH_CAM(A)) dut (
    .clk(clk), .rst_n(rst_n), .host(bus),
    .ap_input_mode(ap_input_mode), .ap_rst_In(ap_rst_In),
    .ap_addr_input_rbr(ap_addr_input_rbr), .ap_addr_input_cbc(ap_addr_input_cbc),
    .ap_addr_output_rbr(ap_addr_output_rbr), .ap_addr_output_cbc(ap_addr_output_cbc),
    .ap_input_row(ap_input_row), .ap_input_col(ap_input_col), .ap_mask(ap_mask),
    .ap_key(ap_key), .ap_tag(ap_tag), .ap_Q_out_row(ap_Q_out_row),
    .ap_Q_out_col(ap_Q_out_col), .ap_tag_row(ap_tag_row)
  );

  // Array model: writes and tag toggles on the edge, two-stage registered read.
  logic [D-1:0][W-1:0] mem = '0;
  logic         oe_row = 1'b0, oe_col = 1'b0;
  logic [A-1:0] oa_row = '0, oa_col = '0;

  always @(posedge clk) begin : array_model
    logic [D-1:0][W-1:0] nx;
    logic [D-1:0]        qc;
    nx = mem;
    if (!ap_rst_In && ap_input_mode == 3'd1 && ap_addr_input_rbr < A'(D))
      nx[ap_addr_input_rbr[3:0]] = ap_input_row;
    if (!ap_rst_In && ap_input_mode == 3'd2 && ap_addr_input_cbc < A'(W))
      for (int r = 0; r < D; r++) nx[r][ap_addr_input_cbc[2:0]] = ap_input_col[r];
    for (int r = 0; r < D; r++) if (ap_tag[r]) nx[r] = nx[r] ^ ap_mask;
    oe_row <= ap_rst_In && ap_input_mode == 3'd1;
    oe_col <= ap_rst_In && ap_input_mode == 3'd2;
    oa_row <= ap_addr_output_rbr;
    oa_col <= ap_addr_output_cbc;
    if (oe_row && oa_row < A'(D)) ap_Q_out_row <= mem[oa_row[3:0]];
    qc = '0;
    for (int r = 0; r < D; r++) qc[r] = mem[r][oa_col[2:0]];
    if (oe_col && oa_col < A'(W)) ap_Q_out_col <= qc;
    mem <= nx;
  end

  always_comb begin
    ap_tag_row = '0;
    for (int r = 0; r < D; r++)
      ap_tag_row[r] = (((mem[r] ^ {W{ap_key}}) & ap_mask) == '0);
  end

  typedef struct {
    logic         err;
    logic [W-1:0] row;
    logic [D-1:0] col;
    logic [D-1:0] tag;
    logic         hit;
    int           due;
  } rsp_t;

  rsp_t         sb[$];
  int           checks = 0, errors = 0;
  int           cyc = 0, nrsp = 0;
  int           tag_cyc = 0, exp_tag_cyc = 0, wen_cyc = 0, exp_wen_cyc = 0;
  logic [W-1:0] hold_row = '0, last_wmask = '0;
  logic [D-1:0] hold_col = '0, hold_tag = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin : monitor
    rsp_t e;
    if (bus.rsp_valid) begin
      nrsp++;
      $display("rsp %0d: err=%0b row=0x%02h col=0x%04h tag=0x%04h hit=%0b cycle=%0d",
               nrsp, bus.rsp_err, bus.rsp_data_row, bus.rsp_data_col, bus.rsp_tag, bus.rsp_hit, cyc);
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_err",      32'(bus.rsp_err),      32'(e.err));
        chk("rsp_data_row", 32'(bus.rsp_data_row), 32'(e.row));
        chk("rsp_data_col", 32'(bus.rsp_data_col), 32'(e.col));
        chk("rsp_tag",      32'(bus.rsp_tag),      32'(e.tag));
        chk("rsp_hit",      32'(bus.rsp_hit),      32'(e.hit));
        chk("rsp_cycle",    32'(cyc),              32'(e.due));
      end
    end
    if (ap_tag != '0) begin
      tag_cyc++;
      chk("toggle_mask", 32'(ap_mask), 32'(last_wmask));
    end
    if (rst_n && !ap_rst_In) wen_cyc++;
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] addr, input logic [15:0] data,
                      input logic [7:0] cmask, input logic [7:0] wmask, input logic key,
                      input logic err, input logic [15:0] expv);
    rsp_t       e;
    int         lat;
    logic [2:0] exp_mode;
    wait_ready();
    if (!bus.cmd_ready) begin
      chk("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
      return;
    end
    bus.cmd_valid    = 1'b1;
    bus.cmd_op       = op;
    bus.cmd_addr     = addr;
    bus.cmd_row_data = data[7:0];
    bus.cmd_col_data = data;
    bus.cmd_cmp_mask = cmask;
    bus.cmd_wr_mask  = wmask;
    bus.cmd_key      = key;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    last_wmask = wmask;
    case (op)
      3'd0:    lat = 0;
      3'd3, 3'd4: lat = 3;
      3'd6:    lat = 2;
      default: lat = 1;
    endcase
    if (err) lat = 0;
    if (err) begin
      hold_row = '0;
      hold_col = '0;
    end else begin
      if (op == 3'd3) hold_row = expv[7:0];
      if (op == 3'd4) hold_col = expv;
      if (op == 3'd5 || op == 3'd6) hold_tag = expv;
      if (op == 3'd1 || op == 3'd2 || op == 3'd7) exp_wen_cyc++;
      if (op == 3'd6) exp_tag_cyc++;
    end
    e.err = err; e.row = hold_row; e.col = hold_col;
    e.tag = hold_tag; e.hit = |hold_tag; e.due = cyc + lat;
    sb.push_back(e);
    case (op)
      3'd1, 3'd3: exp_mode = 3'd1;
      3'd2, 3'd4: exp_mode = 3'd2;
      3'd7:       exp_mode = key ? 3'd5 : 3'd4;
      default:    exp_mode = 3'd0;
    endcase
    if (err) exp_mode = 3'd0;
    $display("cmd op=%0d addr=%0d data=0x%04h cmask=0x%02h wmask=0x%02h key=%0b accepted at cycle %0d",
             op, addr, data, cmask, wmask, key, cyc);
    @(negedge clk);
    chk("ap_input_mode", 32'(ap_input_mode), 32'(exp_mode));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_addr = '0; bus.cmd_row_data = '0;
    bus.cmd_col_data = '0; bus.cmd_cmp_mask = '0; bus.cmd_wr_mask = '0; bus.cmd_key = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_out_rbr",   32'(ap_addr_output_rbr), 32'd19);
    chk("rst_out_cbc",   32'(ap_addr_output_cbc), 32'd11);
    chk("rst_rst_In",    32'(ap_rst_In), 32'd1);
    chk("rst_rsp_tag",   32'(bus.rsp_tag), 32'd0);
    rst_n = 1'b1;
    #1 chk("ready_after_reset", 32'(bus.cmd_ready), 32'd1);

    //   op  addr  data     cmask  wmask  key err expected
    send(1,  3,   16'hA5,   0,     0,     0,  0,  16'h0);
    send(3,  3,   0,        0,     0,     0,  0,  16'hA5);
    send(2,  2,   16'h00FF, 0,     0,     0,  0,  16'h0);
    send(4,  2,   0,        0,     0,     0,  0,  16'h00FF);
    send(3,  0,   0,        0,     0,     0,  0,  16'h04);
    send(1,  0,   16'h0F,   0,     0,     0,  0,  16'h0);
    send(1,  1,   16'h1F,   0,     0,     0,  0,  16'h0);
    send(1,  2,   16'h0E,   0,     0,     0,  0,  16'h0);
    send(1,  3,   16'hFF,   0,     0,     0,  0,  16'h0);
    send(5,  0,   0,        8'h1F, 0,     1,  0,  16'h000A);
    send(3,  1,   0,        0,     0,     0,  0,  16'h1F);
    send(6,  0,   0,        8'h1F, 8'h80, 1,  0,  16'h000A);
    send(3,  0,   0,        0,     0,     0,  0,  16'h0F);
    send(3,  1,   0,        0,     0,     0,  0,  16'h9F);
    send(3,  2,   0,        0,     0,     0,  0,  16'h0E);
    send(3,  3,   0,        0,     0,     0,  0,  16'h7F);
    send(1,  16,  16'h55,   0,     0,     0,  1,  16'h0);
    send(3,  15,  0,        0,     0,     0,  0,  16'h00);
    send(4,  8,   0,        0,     0,     0,  1,  16'h0);
    send(0,  0,   0,        0,     0,     0,  0,  16'h0);
    send(5,  0,   0,        8'h00, 0,     1,  0,  16'hFFFF);
    send(5,  0,   0,        8'h01, 0,     0,  0,  16'hFFF4);
    send(7,  0,   0,        0,     0,     1,  0,  16'h0);
    send(7,  0,   0,        0,     0,     0,  0,  16'h0);

    // Reset while the toggle is being driven: nothing may invert or respond.
    wait_ready();
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd6; bus.cmd_addr = '0;
    bus.cmd_cmp_mask = 8'h1F; bus.cmd_wr_mask = 8'h01; bus.cmd_key = 1'b1;
    $display("cmd op=6 (reset during toggle) issued at cycle %0d", cyc);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ap_tag",    32'(ap_tag), 32'd0);
    chk("abort_ap_mask",   32'(ap_mask), 32'd0);
    chk("abort_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("abort_rsp_tag",   32'(bus.rsp_tag), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold_row = '0; hold_col = '0; hold_tag = '0;
    #1 chk("abort_ready_after_release", 32'(bus.cmd_ready), 32'd1);
    send(3,  1,   0,        0,     0,     0,  0,  16'h9F);
    send(3,  3,   0,        0,     0,     0,  0,  16'h7F);

    repeat (8) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("toggle_cycles",    32'(tag_cyc), 32'(exp_tag_cyc));
    chk("write_cycles",     32'(wen_cyc), 32'(exp_wen_cyc));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
